// File: rtl/ofdm_frame_ctrl_pkg.sv
// Shared types, RATE codes and helpers for the OFDM receive frame controller.
package ofdm_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_HDR = 3'd1,
    S_DIVIDE   = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_EOF = 3'd4
  } state_t;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam int SERVICE_TAIL_BITS = 22;
  localparam int HDR_W             = 17;
  localparam int CNT_W             = 16;

  // Data bits per OFDM symbol; 0 flags a RATE code that is not legal.
  function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
    logic [7:0] ndbps;
    case (rate)
      RATE_6M:  ndbps = 8'd24;
      RATE_9M:  ndbps = 8'd36;
      RATE_12M: ndbps = 8'd48;
      RATE_18M: ndbps = 8'd72;
      RATE_24M: ndbps = 8'd96;
      RATE_36M: ndbps = 8'd144;
      RATE_48M: ndbps = 8'd192;
      RATE_54M: ndbps = 8'd216;
      default:  ndbps = 8'd0;
    endcase
    return ndbps;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ofdm_frame_ctrl_if.sv
// Framer observation taps and decoded-header stream seen by the frame controller.
interface ofdm_frame_ctrl_if;
  import ofdm_frame_ctrl_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where tvalid & tready
  // are both high; the source holds tdata stable while tvalid is high and
  // tready is low, and ready never depends combinationally on valid.
  logic             frm_sof;
  logic             frm_eof;
  logic             frm_tlast;
  logic             frm_tvalid;
  logic             frm_tready;
  logic [HDR_W-1:0] hdr_tdata;
  logic             hdr_tvalid;
  logic             hdr_tready;

  modport master (
    output frm_sof, frm_eof, frm_tlast, frm_tvalid, frm_tready,
    output hdr_tdata, hdr_tvalid,
    input  hdr_tready
  );

  modport slave (
    input  frm_sof, frm_eof, frm_tlast, frm_tvalid, frm_tready,
    input  hdr_tdata, hdr_tvalid,
    output hdr_tready
  );
endinterface

// File: rtl/ofdm_nsym_div.sv
// 16-bit restoring divider with ceiling result and a fixed 16-cycle latency.
module ofdm_nsym_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [15:0] dividend_i,
  input  logic [7:0]  divisor_i,
  output logic        done_o,
  output logic [15:0] quotient_o
);

  logic [15:0] quo_q, quo_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic [8:0]  rem_sh;
  logic [8:0]  rem_sub;
  logic        fits;

  always_comb begin
    rem_sh    = {rem_q[7:0], quo_q[15]};
    rem_sub   = rem_sh - {1'b0, divisor_q};
    fits      = (rem_sh >= {1'b0, divisor_q});

    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    if (start_i) begin
      quo_d     = dividend_i;
      rem_d     = '0;
      divisor_d = divisor_i;
      cnt_d     = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      quo_d  = {quo_q[14:0], fits};
      rem_d  = fits ? rem_sub : rem_sh;
      cnt_d  = cnt_q + 4'd1;
      busy_d = (cnt_q != 4'd15);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // done marks the last iteration cycle; the quotient is final from the next
  // cycle on and stays put until the next start.
  assign done_o     = busy_q && (cnt_q == 4'd15);
  assign quotient_o = quo_q + {15'd0, |rem_q};

endmodule

// File: rtl/ofdm_frame_ctrl.sv
// Frame sequencing controller: turns the SIGNAL header into a symbol count for the framer.
module ofdm_frame_ctrl
  import ofdm_frame_ctrl_pkg::*;
#(
  parameter int MAX_NUM_SYMBOLS = 256,
  parameter int HDR_TIMEOUT     = 4096,
  parameter int NSYM_W          = $clog2(MAX_NUM_SYMBOLS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_passthru,
  output logic                passthru,
  ofdm_frame_ctrl_if.slave    bus,
  output logic [NSYM_W-1:0]   num_symbols,
  output logic                num_symbols_valid,
  output logic [CNT_W-1:0]    cnt_ok,
  output logic [CNT_W-1:0]    cnt_hdr_err,
  output logic [CNT_W-1:0]    cnt_timeout,
  output logic [CNT_W-1:0]    cnt_oversize,
  output state_t              dbg_state
);

  localparam int TMR_W = (HDR_TIMEOUT > 1) ? $clog2(HDR_TIMEOUT + 1) : 1;

  state_t             state_q, state_d;
  logic               passthru_q, passthru_d;
  logic [NSYM_W-1:0]  nsym_q, nsym_d;
  logic               hdr_good_q, hdr_good_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0]   cnt_hdr_err_q, cnt_hdr_err_d;
  logic [CNT_W-1:0]   cnt_timeout_q, cnt_timeout_d;
  logic [CNT_W-1:0]   cnt_oversize_q, cnt_oversize_d;

  logic               frame_end;
  logic               sof_evt;
  logic               hdr_ready;
  logic               hdr_fire;
  logic [3:0]         hdr_rate;
  logic [11:0]        hdr_len;
  logic               hdr_parity_ok;
  logic [7:0]         hdr_ndbps;
  logic               hdr_ok;
  logic [15:0]        bits_total;
  logic               div_start;
  logic               div_done;
  logic [15:0]        div_quot;
  logic [16:0]        nsym_full;
  logic               oversize;
  logic [NSYM_W-1:0]  nsym_clamped;

  assign frame_end = bus.frm_tvalid & bus.frm_tready & bus.frm_tlast & bus.frm_eof;
  assign sof_evt   = bus.frm_sof & bus.frm_tvalid & bus.frm_tready;

  assign hdr_ready      = !reset && (state_q != S_DIVIDE) && (state_q != S_ISSUE);
  assign bus.hdr_tready = hdr_ready;
  assign hdr_fire       = bus.hdr_tvalid & hdr_ready;

  assign hdr_rate      = bus.hdr_tdata[3:0];
  assign hdr_len       = bus.hdr_tdata[15:4];
  assign hdr_parity_ok = bus.hdr_tdata[16];
  assign hdr_ndbps     = rate_to_ndbps(hdr_rate);
  assign hdr_ok        = (hdr_ndbps != 8'd0) && (hdr_len != 12'd0) && hdr_parity_ok;
  assign bits_total    = {1'b0, hdr_len, 3'b000} + 16'(SERVICE_TAIL_BITS);

  assign div_start = (state_q == S_WAIT_HDR) && !frame_end && hdr_fire && hdr_ok;

  ofdm_nsym_div u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (bits_total),
    .divisor_i  (hdr_ndbps),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // The SIGNAL symbol itself is counted on top of the data symbols.
  assign nsym_full    = {1'b0, div_quot} + 17'd1;
  assign oversize     = (nsym_full > 17'(MAX_NUM_SYMBOLS));
  assign nsym_clamped = oversize ? NSYM_W'(MAX_NUM_SYMBOLS) : nsym_full[NSYM_W-1:0];

  always_comb begin
    state_d        = state_q;
    passthru_d     = passthru_q;
    nsym_d         = nsym_q;
    hdr_good_d     = hdr_good_q;
    timer_d        = timer_q;
    cnt_ok_d       = cnt_ok_q;
    cnt_hdr_err_d  = cnt_hdr_err_q;
    cnt_timeout_d  = cnt_timeout_q;
    cnt_oversize_d = cnt_oversize_q;

    case (state_q)
      S_IDLE: begin
        passthru_d = cfg_passthru;
        timer_d    = '0;
        if (!passthru_q && sof_evt) state_d = S_WAIT_HDR;
      end
      S_WAIT_HDR: begin
        timer_d = timer_q + TMR_W'(1);
        // A frame end here means the framer ran into its own cap unaided.
        if (frame_end) begin
          cnt_timeout_d = sat_inc(cnt_timeout_q);
          hdr_good_d    = 1'b0;
          state_d       = S_IDLE;
        end else if (hdr_fire) begin
          if (hdr_ok) begin
            hdr_good_d = 1'b1;
            state_d    = S_DIVIDE;
          end else begin
            nsym_d        = NSYM_W'(1);
            hdr_good_d    = 1'b0;
            cnt_hdr_err_d = sat_inc(cnt_hdr_err_q);
            state_d       = S_WAIT_EOF;
          end
        end else if (timer_q == TMR_W'(HDR_TIMEOUT - 1)) begin
          nsym_d        = NSYM_W'(1);
          hdr_good_d    = 1'b0;
          cnt_timeout_d = sat_inc(cnt_timeout_q);
          state_d       = S_WAIT_EOF;
        end
      end
      S_DIVIDE: begin
        if (div_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        nsym_d = nsym_clamped;
        if (oversize) cnt_oversize_d = sat_inc(cnt_oversize_q);
        state_d = S_WAIT_EOF;
      end
      S_WAIT_EOF: begin
        if (frame_end) begin
          if (hdr_good_q) cnt_ok_d = sat_inc(cnt_ok_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      passthru_q     <= 1'b0;
      nsym_q         <= '0;
      hdr_good_q     <= 1'b0;
      timer_q        <= '0;
      cnt_ok_q       <= '0;
      cnt_hdr_err_q  <= '0;
      cnt_timeout_q  <= '0;
      cnt_oversize_q <= '0;
    end else begin
      state_q        <= state_d;
      passthru_q     <= passthru_d;
      nsym_q         <= nsym_d;
      hdr_good_q     <= hdr_good_d;
      timer_q        <= timer_d;
      cnt_ok_q       <= cnt_ok_d;
      cnt_hdr_err_q  <= cnt_hdr_err_d;
      cnt_timeout_q  <= cnt_timeout_d;
      cnt_oversize_q <= cnt_oversize_d;
    end
  end

  assign passthru          = passthru_q;
  assign num_symbols       = nsym_q;
  assign num_symbols_valid = (state_q == S_WAIT_EOF);
  assign cnt_ok            = cnt_ok_q;
  assign cnt_hdr_err       = cnt_hdr_err_q;
  assign cnt_timeout       = cnt_timeout_q;
  assign cnt_oversize      = cnt_oversize_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// Directed self-checking bench for ofdm_frame_ctrl with hand-computed symbol counts.
module tb_ofdm_frame_ctrl;
  import ofdm_frame_ctrl_pkg::*;

  localparam int MAX_NS = 256;
  localparam int TMO    = 64;
  localparam int NSYM_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_passthru = 1'b0;
  logic              passthru;
  logic [NSYM_W-1:0] num_symbols;
  logic              num_symbols_valid;
  logic [15:0]       cnt_ok, cnt_hdr_err, cnt_timeout, cnt_oversize;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;

  ofdm_frame_ctrl_if bus_if ();

  ofdm_frame_ctrl #(
    .MAX_NUM_SYMBOLS (MAX_NS),
    .HDR_TIMEOUT     (TMO),
    .NSYM_W          (NSYM_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_passthru      (cfg_passthru),
    .passthru          (passthru),
    .bus               (bus_if),
    .num_symbols       (num_symbols),
    .num_symbols_valid (num_symbols_valid),
    .cnt_ok            (cnt_ok),
    .cnt_hdr_err       (cnt_hdr_err),
    .cnt_timeout       (cnt_timeout),
    .cnt_oversize      (cnt_oversize),
    .dbg_state         (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: each drives for one cycle and returns #1 after the closing edge.
  task automatic drive_sof();
    bus_if.frm_sof    = 1'b1;
    bus_if.frm_tvalid = 1'b1;
    bus_if.frm_tready = 1'b1;
    step();
    bus_if.frm_sof    = 1'b0;
    bus_if.frm_tvalid = 1'b0;
    bus_if.frm_tready = 1'b0;
  endtask

  task automatic drive_frame_end(input logic with_sof);
    bus_if.frm_sof    = with_sof;
    bus_if.frm_eof    = 1'b1;
    bus_if.frm_tlast  = 1'b1;
    bus_if.frm_tvalid = 1'b1;
    bus_if.frm_tready = 1'b1;
    step();
    bus_if.frm_sof    = 1'b0;
    bus_if.frm_eof    = 1'b0;
    bus_if.frm_tlast  = 1'b0;
    bus_if.frm_tvalid = 1'b0;
    bus_if.frm_tready = 1'b0;
  endtask

  task automatic drive_hdr(input logic [3:0] rate, input logic [11:0] len, input logic par);
    bus_if.hdr_tdata  = {par, len, rate};
    bus_if.hdr_tvalid = 1'b1;
    chk("hdr_tready_before_accept", 32'(bus_if.hdr_tready), 32'd1);
    step();
    bus_if.hdr_tvalid = 1'b0;
  endtask

  task automatic good_frame(input logic [3:0] rate, input logic [11:0] len, input int exp_n);
    drive_sof();
    drive_hdr(rate, len, 1'b1);
    repeat (17) step();
    chk("good_nsv_T18", 32'(num_symbols_valid), 32'd1);
    chk("good_nsym", 32'(num_symbols), 32'(exp_n));
    drive_frame_end(1'b0);
    chk("good_nsv_after_end", 32'(num_symbols_valid), 32'd0);
  endtask

  task automatic bad_frame(input logic [3:0] rate, input logic [11:0] len, input logic par);
    drive_sof();
    drive_hdr(rate, len, par);
    chk("bad_nsv_T1", 32'(num_symbols_valid), 32'd1);
    chk("bad_nsym_T1", 32'(num_symbols), 32'd1);
    drive_frame_end(1'b0);
  endtask

  initial begin
    bus_if.frm_sof    = 1'b0;
    bus_if.frm_eof    = 1'b0;
    bus_if.frm_tlast  = 1'b0;
    bus_if.frm_tvalid = 1'b0;
    bus_if.frm_tready = 1'b0;
    bus_if.hdr_tdata  = '0;
    bus_if.hdr_tvalid = 1'b0;

    repeat (3) step();
    chk("tready_in_reset", 32'(bus_if.hdr_tready), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));
    chk("reset_nsym", 32'(num_symbols), 32'd0);
    chk("reset_nsv", 32'(num_symbols_valid), 32'd0);
    chk("reset_passthru", 32'(passthru), 32'd0);
    chk("reset_counters", {cnt_ok, cnt_hdr_err} | {cnt_timeout, cnt_oversize}, 32'd0);
    reset = 1'b0;
    step();
    chk("tready_idle", 32'(bus_if.hdr_tready), 32'd1);

    // RATE 1101 LENGTH 100: 822 bits / 24 -> 35, plus SIGNAL -> 36, walked cycle by cycle
    drive_sof();
    chk("sof_to_wait_hdr", 32'(dbg_state), 32'(S_WAIT_HDR));
    drive_hdr(4'b1101, 12'd100, 1'b1);
    chk("T1_divide", 32'(dbg_state), 32'(S_DIVIDE));
    chk("T1_tready_low", 32'(bus_if.hdr_tready), 32'd0);
    repeat (15) step();
    chk("T16_divide", 32'(dbg_state), 32'(S_DIVIDE));
    step();
    chk("T17_issue", 32'(dbg_state), 32'(S_ISSUE));
    chk("T17_nsv_low", 32'(num_symbols_valid), 32'd0);
    step();
    chk("T18_nsv", 32'(num_symbols_valid), 32'd1);
    chk("T18_nsym_36", 32'(num_symbols), 32'd36);
    step();
    chk("nsym_stable", 32'(num_symbols), 32'd36);
    drive_frame_end(1'b0);
    chk("end_nsv_low", 32'(num_symbols_valid), 32'd0);
    chk("cnt_ok_1", 32'(cnt_ok), 32'd1);

    // 12022/216 -> 56 -> 57 ; 406/192 -> 3 -> 4 ; 32782/24 -> 1366 -> 1367 clamped to 256
    good_frame(4'b0011, 12'd1500, 57);
    good_frame(4'b0001, 12'd48, 4);
    good_frame(4'b1101, 12'd4095, 256);
    chk("cnt_oversize_1", 32'(cnt_oversize), 32'd1);
    chk("cnt_ok_4", 32'(cnt_ok), 32'd4);

    bad_frame(4'b1000, 12'd100, 1'b1);
    bad_frame(4'b1101, 12'd100, 1'b0);
    bad_frame(4'b1101, 12'd0, 1'b1);
    chk("cnt_hdr_err_3", 32'(cnt_hdr_err), 32'd3);
    chk("cnt_ok_after_bad", 32'(cnt_ok), 32'd4);

    // Header timeout: SOF in cycle S, valid must rise at S+65
    drive_sof();
    repeat (63) step();
    chk("tmo_S64_nsv_low", 32'(num_symbols_valid), 32'd0);
    chk("tmo_S64_state", 32'(dbg_state), 32'(S_WAIT_HDR));
    step();
    chk("tmo_S65_nsv", 32'(num_symbols_valid), 32'd1);
    chk("tmo_nsym_1", 32'(num_symbols), 32'd1);
    chk("cnt_timeout_1", 32'(cnt_timeout), 32'd1);
    drive_hdr(4'b1101, 12'd100, 1'b1);
    chk("late_hdr_state", 32'(dbg_state), 32'(S_WAIT_EOF));
    chk("late_hdr_no_err", 32'(cnt_hdr_err), 32'd3);
    chk("late_hdr_nsym", 32'(num_symbols), 32'd1);
    drive_frame_end(1'b1);
    chk("sof_on_end_ignored", 32'(dbg_state), 32'(S_IDLE));
    chk("tmo_cnt_ok_same", 32'(cnt_ok), 32'd4);
    step();
    chk("still_idle", 32'(dbg_state), 32'(S_IDLE));

    // Framer reaches its cap before any header arrives
    drive_sof();
    repeat (3) step();
    drive_frame_end(1'b0);
    chk("cap_end_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("cnt_timeout_2", 32'(cnt_timeout), 32'd2);

    // passthru only follows cfg in S_IDLE
    drive_sof();
    drive_hdr(4'b1000, 12'd10, 1'b1);
    cfg_passthru = 1'b1;
    repeat (2) step();
    chk("pt_held_in_eof", 32'(passthru), 32'd0);
    drive_frame_end(1'b0);
    chk("pt_held_at_end", 32'(passthru), 32'd0);
    step();
    chk("pt_updated_idle", 32'(passthru), 32'd1);
    drive_sof();
    chk("pt_sof_ignored", 32'(dbg_state), 32'(S_IDLE));
    cfg_passthru = 1'b0;
    step();
    chk("pt_cleared", 32'(passthru), 32'd0);

    // Reset during S_DIVIDE
    drive_sof();
    drive_hdr(4'b1101, 12'd100, 1'b1);
    repeat (4) step();
    chk("pre_reset_divide", 32'(dbg_state), 32'(S_DIVIDE));
    reset = 1'b1;
    step();
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_nsym", 32'(num_symbols), 32'd0);
    chk("rst_nsv", 32'(num_symbols_valid), 32'd0);
    chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
    chk("rst_cnt_hdr_err", 32'(cnt_hdr_err), 32'd0);
    chk("rst_cnt_timeout", 32'(cnt_timeout), 32'd0);
    chk("rst_cnt_oversize", 32'(cnt_oversize), 32'd0);
    chk("rst_tready", 32'(bus_if.hdr_tready), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_tready", 32'(bus_if.hdr_tready), 32'd1);
    good_frame(4'b0111, 12'd200, 24);
    chk("post_rst_cnt_ok", 32'(cnt_ok), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdm_frame_ctrl.md
# ofdm_frame_ctrl

Sequencing controller for the OFDM receive framer. It watches the framer's output stream and accepts the decoded SIGNAL header from the downstream decoder. From RATE and LENGTH it computes the total symbol count, then drives the framer's `num_symbols`/`num_symbols_valid` so each frame ends on the right symbol. It also gates the framer's passthru mode to frame boundaries, aborts frames with bad or missing headers, and keeps saturating status counters.

## Interface
Parameters:
- `MAX_NUM_SYMBOLS`, 256: framer symbol cap; computed counts are clamped to this value.
- `HDR_TIMEOUT`, 4096: number of cycles after SOF to wait for a header before aborting.
- `NSYM_W`, `$clog2(MAX_NUM_SYMBOLS+1)`: width of `num_symbols`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cfg_passthru`  in  1  requested passthru mode.
- `passthru`  out  1  passthru to framer; updates only in S_IDLE.
- `frm_sof`, `frm_eof`, `frm_tlast`, `frm_tvalid`, `frm_tready`  in  1 each  framer output observation taps.
- `hdr_tdata`  in  17  header word: [3:0] RATE, [15:4] LENGTH, [16] parity_ok.
- `hdr_tvalid`  in  1  header valid.
- `hdr_tready`  out  1  header ready.
- `num_symbols`  out  NSYM_W  symbol count to framer; includes the SIGNAL symbol.
- `num_symbols_valid`  out  1  level signal, held until the frame ends.
- `cnt_ok`, `cnt_hdr_err`, `cnt_timeout`, `cnt_oversize`  out  16 each  saturating event counters.

## Operation
Definitions:
- frame end = `frm_tvalid & frm_tready & frm_tlast & frm_eof`.
- SOF event = `frm_sof & frm_tvalid & frm_tready`.

States:
- **S_IDLE**
  - `passthru <= cfg_passthru` every cycle.
  - `num_symbols_valid = 0`; timer is cleared.
  - If `passthru` is 0 and an SOF event occurs, go to S_WAIT_HDR.
- **S_WAIT_HDR**
  - Timer increments each cycle.
  - On header handshake, validate the header (rules below):
    - valid header: go to S_DIVIDE;
    - invalid header: `num_symbols <= 1`, `cnt_hdr_err++`, go to S_WAIT_EOF.
  - If timer = HDR_TIMEOUT-1 with no header: `num_symbols <= 1`, `cnt_timeout++`, go to S_WAIT_EOF.
  - If frame end occurs first (framer hit its cap): `cnt_timeout++`, go to S_IDLE.
- **S_DIVIDE**
  - 16-cycle restoring divide of BITS = 8·LENGTH + 22 (16 bits) by N_DBPS.
  - Quotient Q is rounded up when the remainder is nonzero.
  - Then go to S_ISSUE.
- **S_ISSUE** (one cycle)
  - N = Q + 1.
  - If N > MAX_NUM_SYMBOLS: N = MAX_NUM_SYMBOLS and `cnt_oversize++`.
  - `num_symbols <= N`; go to S_WAIT_EOF.
- **S_WAIT_EOF**
  - `num_symbols_valid = 1`.
  - On frame end: go to S_IDLE. Increment `cnt_ok` only if the header was good.

Header validation:
- RATE to N_DBPS mapping: 1101→24, 1111→36, 0101→48, 0111→72, 1001→96, 1011→144, 0001→192, 0011→216.
- Any other RATE, LENGTH = 0, or `parity_ok` = 0 makes the header invalid.
- Setting `num_symbols` = 1 on an invalid header makes the framer stop at its next symbol boundary.

Header handshake:
- `hdr_tready` = 1 in all states except S_DIVIDE and S_ISSUE, and 0 while `reset` is high.
- A header accepted outside S_WAIT_HDR is discarded with no other effect.

Other rules:
- An SOF event outside S_IDLE is ignored.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: state S_IDLE, `passthru` 0, `num_symbols` 0, `num_symbols_valid` 0, all counters 0.
- Reset mid-frame returns to S_IDLE in the next cycle; no counter increments.
- Valid header accepted in cycle T: S_DIVIDE occupies T+1..T+16, S_ISSUE is T+17, and `num_symbols_valid` rises at T+18.
- Invalid header accepted in cycle T: `num_symbols` = 1 and `num_symbols_valid` rise at T+1.
- Timeout: with SOF at cycle S, `num_symbols_valid` rises at S+HDR_TIMEOUT+1.
- `num_symbols_valid` falls the cycle after frame end. `num_symbols` stays stable while valid is high.
- A frame-end cycle returns to S_IDLE. An SOF on that same cycle is not seen.
- `passthru` changes at most once per cycle and only in S_IDLE. While `passthru` = 1, SOF events are ignored.

## Structure
- Package `ofdm_frame_ctrl_pkg`:
  - state enum;
  - RATE code localparams;
  - function `rate_to_ndbps` (returns 0 for an invalid rate);
  - constant `SERVICE_TAIL_BITS` = 22.
- Sub-module `ofdm_nsym_div`:
  - 16-bit restoring ceiling divider, start/done handshake, fixed 16-cycle latency;
  - inputs: 16-bit dividend, 8-bit divisor.

## Test plan
- RATE 1101, LENGTH 100, header accepted at T: `num_symbols` = 36 and `num_symbols_valid` rise at T+18; after frame end, `cnt_ok` = 1.
- RATE 0011, LENGTH 1500: `num_symbols` = 57. RATE 0001, LENGTH 48: BITS = 406, `num_symbols` = 4 (rounded up).
- RATE 1101, LENGTH 4095: `num_symbols` = 256 (clamped from 1367); `cnt_oversize` = 1.
- RATE 1000, or `parity_ok` = 0, or LENGTH 0: `num_symbols` = 1 at T+1; `cnt_hdr_err` increments; `cnt_ok` is unchanged at frame end.
- SOF with no header, HDR_TIMEOUT = 64: `num_symbols_valid` rises 65 cycles after SOF; `cnt_timeout` = 1. A late header is consumed and discarded.
- Raise `cfg_passthru` in S_WAIT_EOF: `passthru` changes only after frame end. Assert `reset` in S_DIVIDE: all outputs return to their reset values in the next cycle.
